// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle controller for a small MIPS subset. Sequences each
// instruction through FETCH..WB and drives PC/IR/GRF/DM enables from the current state.
module mc_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             zero,
  output logic             pc_we,
  output logic [1:0]       npc_sel,
  output logic             ir_we,
  output logic             reg_we,
  output logic             mem_we,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] instr_cnt
);

  // state  | meaning
  // FETCH  | load IR; always followed by DECODE
  // DECODE | register read; j/jr/unknown retire here
  // EXEC   | ALU operation; beq retires here
  // MEM    | data memory access; sw retires here
  // WB     | GRF write; addu/subu/ori/lui/lw/jal retire here
  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_instr_cnt;

  logic w_alu, w_lw, w_sw, w_beq, w_j, w_jal, w_jr, w_unk;
  logic w_pc_we, w_ir_we, w_reg_we, w_mem_we;
  logic [1:0] w_npc_sel;

  assign w_alu = ((opcode == 6'h00) && ((funct == 6'h21) || (funct == 6'h23)))
                 || (opcode == 6'h0d) || (opcode == 6'h0f);
  assign w_jr  = (opcode == 6'h00) && (funct == 6'h08);
  assign w_lw  = (opcode == 6'h23);
  assign w_sw  = (opcode == 6'h2b);
  assign w_beq = (opcode == 6'h04);
  assign w_j   = (opcode == 6'h02);
  assign w_jal = (opcode == 6'h03);
  assign w_unk = !(w_alu || w_jr || w_lw || w_sw || w_beq || w_j || w_jal);

  always_comb begin
    w_pc_we   = 1'b0;
    w_ir_we   = 1'b0;
    w_reg_we  = 1'b0;
    w_mem_we  = 1'b0;
    w_npc_sel = 2'd0;
    case (r_state)
      S_FETCH:  w_ir_we = 1'b1;
      S_DECODE: w_pc_we = w_j || w_jr || w_unk;
      S_EXEC:   w_pc_we = w_beq;
      S_MEM: begin
        w_pc_we  = w_sw;
        w_mem_we = w_sw;
      end
      S_WB: begin
        w_pc_we  = w_alu || w_lw || w_jal;
        w_reg_we = w_alu || w_lw || w_jal;
      end
      default: ;
    endcase
    // npc_sel is only meaningful on the retiring cycle; held at 0 otherwise
    if (w_pc_we) begin
      if (w_beq && zero)      w_npc_sel = 2'd1;
      else if (w_j || w_jal)  w_npc_sel = 2'd2;
      else if (w_jr)          w_npc_sel = 2'd3;
      else                    w_npc_sel = 2'd0;
    end
  end

  assign pc_we     = w_pc_we  && !reset;
  assign ir_we     = w_ir_we  && !reset;
  assign reg_we    = w_reg_we && !reset;
  assign mem_we    = w_mem_we && !reset;
  assign npc_sel   = reset ? 2'd0 : w_npc_sel;
  assign state     = r_state;
  assign instr_cnt = r_instr_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_FETCH;
      r_instr_cnt <= '0;
    end else begin
      if (w_pc_we) r_instr_cnt <= r_instr_cnt + CNT_W'(1);
      case (r_state)
        S_FETCH: r_state <= S_DECODE;
        S_DECODE: begin
          if (w_jal)                                r_state <= S_WB;
          else if (w_alu || w_lw || w_sw || w_beq)  r_state <= S_EXEC;
          else                                      r_state <= S_FETCH;
        end
        S_EXEC: begin
          if (w_lw || w_sw)  r_state <= S_MEM;
          else if (w_alu)    r_state <= S_WB;
          else               r_state <= S_FETCH;
        end
        S_MEM: begin
          if (w_lw)  r_state <= S_WB;
          else       r_state <= S_FETCH;
        end
        default: r_state <= S_FETCH;
      endcase
    end
  end

endmodule

// File: doc/mc_ctrl.md
MC_CTRL -- requirements
Module: mc_ctrl

Interface
REQ-001 SHALL have parameter: CNT_W, 32, width of retired-instruction counter.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port: opcode  input  6  Instr[31:26] from the instruction register; stable after FETCH.
REQ-005 SHALL have port: funct  input  6  Instr[5:0].
REQ-006 SHALL have port: zero  input  1  ALU equality flag; sampled only in EXEC.
REQ-007 SHALL have port: pc_we  output  1  PC register write enable; PC loads Npc on the next edge.
REQ-008 SHALL have port: npc_sel  output  2  Npc source: 0 = PC+4; 1 = PC+4+(sext(imm)<<2); 2 = jump target; 3 = GPR[rs].
REQ-009 SHALL have port: ir_we  output  1  instruction register load enable.
REQ-010 SHALL have port: reg_we  output  1  GRF write enable.
REQ-011 SHALL have port: mem_we  output  1  DM write enable.
REQ-012 SHALL have port: state  output  3  current state code.
REQ-013 SHALL have port: instr_cnt  output  CNT_W  count of retired instructions.

Function
REQ-014 SHALL use the state codes FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4; codes 5-7 SHALL return to FETCH on the next edge with all enables 0.
REQ-015 SHALL decode: R-type = opcode 0x00 with funct 0x21 (addu) or 0x23 (subu); jr = opcode 0x00 with funct 0x08; ori = 0x0d; lui = 0x0f; lw = 0x23; sw = 0x2b; beq = 0x04; j = 0x02; jal = 0x03; any other encoding is UNKNOWN.
REQ-016 SHALL drive ir_we=1 in FETCH only; FETCH always goes to DECODE.
REQ-017 SHALL sequence the classes as follows (the last state listed is the completion state):
- addu/subu/ori/lui: FETCH, DECODE, EXEC, WB.
- lw: FETCH, DECODE, EXEC, MEM, WB.
- sw: FETCH, DECODE, EXEC, MEM.
- beq: FETCH, DECODE, EXEC.
- jal: FETCH, DECODE, WB.
- j, jr and UNKNOWN: FETCH, DECODE.
REQ-018 SHALL assert pc_we=1 for exactly one cycle per instruction, in its completion state, and then return to FETCH.
REQ-019 SHALL set npc_sel to 1 for beq when zero=1, 0 for beq when zero=0, 2 for j and jal, 3 for jr, and 0 for all other classes.
REQ-020 SHALL hold npc_sel at 0 in every cycle where pc_we=0.
REQ-021 SHALL assert reg_we=1 only in WB; mem_we=1 only in MEM for sw. These enables are never asserted in the same cycle.
REQ-022 SHALL treat UNKNOWN as a no-op: no reg_we or mem_we, npc_sel=0.
REQ-023 SHALL make all outputs combinational functions of state, opcode, funct and zero, with no extra latency.
REQ-024 SHALL increment instr_cnt by 1 on every edge where pc_we=1, wrapping modulo 2^CNT_W with no saturation.

Reset
REQ-025 SHALL on reset assertion immediately (asynchronously) force state=FETCH and instr_cnt=0.
REQ-026 SHALL force pc_we, ir_we, reg_we and mem_we to 0 and npc_sel to 0 while reset is high, including a reset arriving mid-instruction; no partial write completes.
REQ-027 SHALL, after reset deasserts, enter FETCH with ir_we=1 on the first cycle; the PC reset value 0x00003000 belongs to the PC register, not to this block.

Verification
REQ-028 SHALL pass: lw (opcode 0x23) after reset -> states 0,1,2,3,4; reg_we=1 and pc_we=1 only in the 5th cycle; npc_sel=0; instr_cnt=1.
REQ-029 SHALL pass: beq with zero=1 in EXEC -> states 0,1,2; npc_sel=1 with pc_we=1 in EXEC. Repeat with zero=0 -> npc_sel=0.
REQ-030 SHALL pass: jal then jr (opcode 0, funct 0x08) -> jal gives 0,1,4 with reg_we=1, npc_sel=2 in WB; jr gives 0,1 with npc_sel=3, reg_we=0; instr_cnt=2.
REQ-031 SHALL pass: sw, then opcode 0x3f (UNKNOWN) -> sw gives mem_we=1 and pc_we=1 in MEM only; UNKNOWN completes in DECODE with no GRF or DM write.
REQ-032 SHALL pass: reset asserted asynchronously during MEM of a lw -> state=0, all enables 0 before the next clock edge, instr_cnt=0.
REQ-033 SHALL pass: CNT_W=4 with 16 j instructions -> instr_cnt wraps from 15 to 0.
